ifq_rom_queue: RTL and testbench

Multi-entry, ROM-backed instruction fetch queue for FPGA builds; a drop-in successor to the single-cycle stub. It sits between the instruction cache miss path and a synchronous boot/program ROM. It accepts line-miss allocations into a configurable-depth queue and merges duplicate line requests. It issues pipelined ROM reads that tolerate a configurable fixed ROM latency, and returns filled lines to the cache in allocation order.

---
 rtl/ifq_rom_queue.sv | 132 +++++++++++++
 tb/tb_ifq_rom_queue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifq_rom_queue.sv
// rtl/ifq_rom_queue.sv - ROM-backed multi-entry instruction fetch queue with duplicate-line merge
// Pipelined fixed-latency ROM reads; fills are returned to the cache in allocation order.
module ifq_rom_queue #(
    parameter int OPTN_ADDR_WIDTH   = 32,
    parameter int OPTN_IC_LINE_SIZE = 32,
    parameter int OPTN_HEX_SIZE     = 1024,
    parameter int OPTN_IFQ_DEPTH    = 4,
    parameter int OPTN_ROM_LATENCY  = 1,
    parameter int IC_LINE_WIDTH     = OPTN_IC_LINE_SIZE * 8,
    parameter int ROM_ADDR_WIDTH    = (OPTN_HEX_SIZE == 1) ? 1 : $clog2(OPTN_HEX_SIZE)
) (
    input  logic                       clk,
    input  logic                       n_rst,
    output logic                       o_full,
    output logic                       o_rom_en,
    output logic [ROM_ADDR_WIDTH-1:0]  o_rom_addr,
    input  logic [IC_LINE_WIDTH-1:0]   i_rom_data,
    input  logic                       i_alloc_en,
    input  logic [OPTN_ADDR_WIDTH-1:0] i_alloc_addr,
    output logic                       o_fill_en,
    output logic [OPTN_ADDR_WIDTH-1:0] o_fill_addr,
    output logic [IC_LINE_WIDTH-1:0]   o_fill_data
);

    localparam int OFF_W  = $clog2(OPTN_IC_LINE_SIZE);
    localparam int LINE_W = OPTN_ADDR_WIDTH - OFF_W;
    localparam int PTR_W  = $clog2(OPTN_IFQ_DEPTH);
    localparam int CNT_W  = $clog2(OPTN_IFQ_DEPTH + 1);
    localparam int LAT    = OPTN_ROM_LATENCY;

    logic [OPTN_IFQ_DEPTH-1:0] r_valid;
    logic [OPTN_IFQ_DEPTH-1:0] r_issued;
    logic [LINE_W-1:0]         r_line [OPTN_IFQ_DEPTH];
    logic [PTR_W-1:0]          r_tail;
    logic [PTR_W-1:0]          r_issue;
    logic [PTR_W-1:0]          r_head;
    logic [CNT_W-1:0]          r_count;
    logic [LAT-1:0]            r_lat;

    logic [LINE_W-1:0] w_alloc_line;
    logic              w_dup;
    logic              w_alloc_ok;
    logic              w_ret;
    logic [LAT:0]      w_lat_shift;
    logic              w_unused_offset;

    assign w_alloc_line    = i_alloc_addr[OPTN_ADDR_WIDTH-1:OFF_W];
    assign w_unused_offset = ^i_alloc_addr[OFF_W-1:0];

    // A retiring entry is still valid in r_valid this cycle, so it also suppresses duplicates.
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < OPTN_IFQ_DEPTH; i++) begin
            if (r_valid[i] && (r_line[i] == w_alloc_line)) begin
                w_dup = 1'b1;
            end
        end
    end

    assign o_full      = (r_count == CNT_W'(OPTN_IFQ_DEPTH));
    assign w_alloc_ok  = i_alloc_en && !o_full && !w_dup;
    assign o_rom_en    = r_valid[r_issue] && !r_issued[r_issue];
    assign o_rom_addr  = ROM_ADDR_WIDTH'(r_line[r_issue]);
    assign w_ret       = r_lat[LAT-1];
    assign w_lat_shift = {r_lat, o_rom_en};

    // Fixed ROM latency means returns arrive in issue order, which is also head order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_lat <= '0;
        end else begin
            r_lat <= w_lat_shift[LAT-1:0];
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_valid  <= '0;
            r_issued <= '0;
            r_tail   <= '0;
            r_issue  <= '0;
            r_head   <= '0;
        end else begin
            if (w_alloc_ok) begin
                r_valid[r_tail]  <= 1'b1;
                r_issued[r_tail] <= 1'b0;
                r_tail           <= r_tail + 1'b1;
            end
            if (o_rom_en) begin
                r_issued[r_issue] <= 1'b1;
                r_issue           <= r_issue + 1'b1;
            end
            if (w_ret) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc_ok) begin
            r_line[r_tail] <= w_alloc_line;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else begin
            case ({w_alloc_ok, w_ret})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_fill_en   <= 1'b0;
            o_fill_addr <= '0;
            o_fill_data <= '0;
        end else begin
            o_fill_en <= w_ret;
            if (w_ret) begin
                o_fill_addr <= OPTN_ADDR_WIDTH'(r_line[r_head]) << OFF_W;
                o_fill_data <= i_rom_data;
            end
        end
    end

endmodule

// File: tb/tb_ifq_rom_queue.sv
// tb/tb_ifq_rom_queue.sv - bench for ifq_rom_queue: L=1 and L=3 instances against a timing-level queue model
module tb_ifq_rom_queue;

    localparam int AW = 32;
    localparam int LW = 256;
    localparam int RA = 10;
    localparam int D  = 4;
    localparam int MAXE = 1024;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            alloc_en;
    logic [AW-1:0]   alloc_addr;
    logic [1:0]      full;
    logic [1:0]      ren;
    logic [1:0]      fen;
    logic [RA-1:0]   raddr [2];
    logic [AW-1:0]   faddr [2];
    logic [LW-1:0]   fdata [2];
    logic [LW-1:0]   rd0;
    logic [LW-1:0]   rd1;
    logic [LW-1:0]   p1;
    logic [LW-1:0]   p2;

    int nvec = 0;
    int nfail = 0;
    int t = 0;
    int fcnt [2];
    int rcnt [2];

    int m_line [2][MAXE];
    int m_al   [2][MAXE];
    int m_is   [2][MAXE];
    int m_ret  [2][MAXE];
    int m_n    [2];
    int m_last [2];

    always #5 clk = ~clk;

    ifq_rom_queue #(.OPTN_ROM_LATENCY(1), .OPTN_IFQ_DEPTH(D)) dut0 (
        .clk(clk), .n_rst(n_rst), .o_full(full[0]), .o_rom_en(ren[0]), .o_rom_addr(raddr[0]),
        .i_rom_data(rd0), .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr),
        .o_fill_en(fen[0]), .o_fill_addr(faddr[0]), .o_fill_data(fdata[0]));

    ifq_rom_queue #(.OPTN_ROM_LATENCY(3), .OPTN_IFQ_DEPTH(D)) dut1 (
        .clk(clk), .n_rst(n_rst), .o_full(full[1]), .o_rom_en(ren[1]), .o_rom_addr(raddr[1]),
        .i_rom_data(rd1), .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr),
        .o_fill_en(fen[1]), .o_fill_addr(faddr[1]), .o_fill_data(fdata[1]));

    function automatic logic [LW-1:0] rom_f(input logic [RA-1:0] a);
        logic [LW-1:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = ({22'd0, a} * 32'h9E37_79B1) ^ (32'h0101_0101 * 32'(i + 1));
        end
        return r;
    endfunction

    // Synchronous ROMs with 1 and 3 cycles of latency.
    always @(posedge clk) begin
        rd0 <= rom_f(raddr[0]);
        p1  <= rom_f(raddr[1]);
        p2  <= p1;
        rd1 <= p2;
    end

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int occ(input int k, input int tc);
        int n = 0;
        for (int j = 0; j < m_n[k]; j++) if (m_al[k][j] < tc && m_ret[k][j] >= tc) n++;
        return n;
    endfunction

    function automatic bit dup(input int k, input int tc, input int line);
        for (int j = 0; j < m_n[k]; j++)
            if (m_al[k][j] < tc && m_ret[k][j] >= tc && m_line[k][j] == line) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_n[k]    = 0;
            m_last[k] = -100;
        end
    endtask

    // Check the current cycle against the model, drive this cycle's alloc, advance one clock.
    task automatic step(input bit en, input logic [AW-1:0] a);
        for (int k = 0; k < 2; k++) begin
            bit e_ren = 0;
            bit e_fill = 0;
            int r_line = 0;
            int f_line = 0;
            for (int j = 0; j < m_n[k]; j++) begin
                if (m_is[k][j] == t)      begin e_ren = 1; r_line = m_line[k][j]; end
                if (m_ret[k][j] + 1 == t) begin e_fill = 1; f_line = m_line[k][j]; end
            end
            chk($sformatf("d%0d rom_en t=%0d", k, t), LW'(ren[k]), LW'(e_ren));
            if (e_ren) chk($sformatf("d%0d rom_addr t=%0d", k, t), LW'(raddr[k]), LW'(r_line % 1024));
            chk($sformatf("d%0d fill_en t=%0d", k, t), LW'(fen[k]), LW'(e_fill));
            if (e_fill) begin
                chk($sformatf("d%0d fill_addr t=%0d", k, t), LW'(faddr[k]), LW'(32'(f_line) << 5));
                chk($sformatf("d%0d fill_data t=%0d", k, t), fdata[k], rom_f(RA'(f_line % 1024)));
            end
            chk($sformatf("d%0d full t=%0d", k, t), LW'(full[k]), LW'(occ(k, t) == D));
            if (fen[k] === 1'b1) fcnt[k]++;
            if (ren[k] === 1'b1) rcnt[k]++;
        end
        alloc_en   = en;
        alloc_addr = a;
        if (en) begin
            for (int k = 0; k < 2; k++) begin
                int line = int'(a >> 5);
                if (occ(k, t) < D && !dup(k, t, line)) begin
                    int n = m_n[k];
                    m_line[k][n] = line;
                    m_al[k][n]   = t;
                    m_is[k][n]   = (t + 1 > m_last[k] + 1) ? t + 1 : m_last[k] + 1;
                    m_ret[k][n]  = m_is[k][n] + lat(k);
                    m_last[k]    = m_is[k][n];
                    m_n[k]       = n + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    task automatic mid_reset();
        n_rst    = 1'b0;
        alloc_en = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d rst full", k), LW'(full[k]), '0);
            chk($sformatf("d%0d rst rom_en", k), LW'(ren[k]), '0);
            chk($sformatf("d%0d rst fill_en", k), LW'(fen[k]), '0);
            chk($sformatf("d%0d rst fill_addr", k), LW'(faddr[k]), '0);
            chk($sformatf("d%0d rst fill_data", k), fdata[k], '0);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_rst = 1'b1;
        model_clear();
    endtask

    initial begin
        int f0;
        int r0;
        int n;
        fcnt = '{0, 0};
        rcnt = '{0, 0};
        n_rst      = 1'b1;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        model_clear();
        @(posedge clk);
        #1;
        mid_reset();

        // Single alloc latency on L=1
        step(1'b1, 32'h0000_0104);
        chk("t1 rom_en", LW'(ren[0]), LW'(1'b1));
        chk("t1 rom_addr", LW'(raddr[0]), LW'(10'd8));
        idle(2);
        chk("t1 fill_en", LW'(fen[0]), LW'(1'b1));
        chk("t1 fill_addr", LW'(faddr[0]), LW'(32'h0000_0100));
        chk("t1 fill_data", fdata[0], rom_f(10'd8));
        idle(6);

        // Fill the L=3 queue, then a dropped fifth alloc
        f0 = fcnt[1];
        for (int i = 0; i < 4; i++) step(1'b1, 32'h1000 + 32'(i * 32));
        chk("t2 full", LW'(full[1]), LW'(1'b1));
        step(1'b1, 32'h1080);
        idle(12);
        chk("t2 fills", LW'(fcnt[1] - f0), LW'(4));

        // Duplicate merge on L=1
        r0 = rcnt[0];
        f0 = fcnt[0];
        step(1'b1, 32'h200);
        step(1'b1, 32'h21C);
        idle(8);
        chk("t3 rom reads", LW'(rcnt[0] - r0), LW'(1));
        chk("t3 fills", LW'(fcnt[0] - f0), LW'(1));

        // Back-to-back A,B,C on L=3
        step(1'b1, 32'h300);
        step(1'b1, 32'h320);
        step(1'b1, 32'h340);
        idle(10);

        // Reset between issue and return
        step(1'b1, 32'h400);
        step(1'b0, '0);
        mid_reset();
        f0 = fcnt[1];
        idle(8);
        chk("t5 no stale fill", LW'(fcnt[1] - f0), LW'(0));
        step(1'b1, 32'h440);
        idle(6);
        chk("t5 fresh fill", LW'(fcnt[1] - f0), LW'(1));

        // Ten sequential allocs honouring o_full
        f0 = fcnt[1];
        n  = 0;
        for (int i = 0; i < 200 && n < 10; i++) begin
            if (full[1] === 1'b0) begin
                step(1'b1, 32'h800 + 32'(n * 32));
                n++;
            end else begin
                step(1'b0, '0);
            end
        end
        chk("t6 allocs issued", LW'(n), LW'(10));
        idle(10);
        chk("t6 fills", LW'(fcnt[1] - f0), LW'(10));

        // Random traffic over a small line pool
        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] a;
            a = (32'(64 + $urandom_range(0, 11)) << 5) | 32'($urandom_range(0, 31));
            step($urandom_range(0, 3) != 0, a);
        end
        idle(15);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
